fetch_queue_stage: RTL and testbench
====================================

// Module: fetch_queue_stage
// PURPOSE
//  Pipelined IF stage: issues instruction fetches on an SRAM-like req/addr_ok/data_ok bus with up to
//  DEPTH requests in flight, buffers returned words in a DEPTH-entry queue and presents one {pc,inst}
//  per cycle to decode. Handles stall/stop, and flushes on exception/eret by redirecting the PC and
//  silently discarding responses still in flight. Sits between the inst bus bridge and decode.
// PARAMETERS
//  RESET_PC   32'hbfc00000  PC after reset
//  EXC_PC     32'hbfc00380  redirect target on exception
//  DEPTH      4             queue entries = max outstanding+buffered fetches; power of 2, >=2
// PORTS
//  clk           in   1   clock
//  resetn        in   1   reset, synchronous, active-low
//  stall         in   1   decode not accepting; hold output register
//  stop          in   1   global freeze (highest priority after reset)
//  exception     in   1   flush, redirect to EXC_PC
//  return        in   1   eret: flush, redirect to ret_pc
//  ret_pc        in   32  eret target (EPC)
//  inst_req      out  1   fetch request
//  inst_addr     out  32  fetch address, stable while inst_req && !inst_addr_ok
//  inst_addr_ok  in   1   request accepted this cycle
//  inst_data_ok  in   1   oldest accepted request returns this cycle
//  inst_rdata    in   32  returned instruction
//  fe_valid      out  1   fe_pc/fe_inst hold a live instruction
//  fe_pc         out  32  PC of presented instruction
//  fe_inst       out  32  presented instruction; 0 when !fe_valid
// BEHAVIOUR
//  - Reset: pc_r=RESET_PC, inst_req=0, queue/tag FIFO empty, inflight=0, discard=0, fe_valid=0,
//    fe_pc=RESET_PC, fe_inst=0. Reset mid-operation drops everything; bus owner is reset too.
//  - Priority each cycle: reset > stop > flush(exception > return) > stall > normal.
//  - Issue: inst_req=1 when !stop && !flush && inflight+count<DEPTH. addr_ok fire: push inst_addr into
//    tag FIFO, inflight++, pc_r+=4 (wraps mod 2^32). inst_addr=pc_r.
//  - Return: data_ok fire: pop tag, inflight--. If discard>0: discard--, word dropped. Else if queue
//    empty and output accepting: word+tag go straight to fe_* next edge (1-cycle, no bypass bubble);
//    else pushed to queue. Credit rule guarantees queue never overflows; overflow is an assertion.
//  - addr_ok and data_ok in same cycle: inflight unchanged, push and pop both performed.
//  - Output accepting = !stall && !stop. Accepting: load queue head (fe_valid=1) or bypass word;
//    if neither, fe_valid=0, fe_inst=0, fe_pc holds. Not accepting: fe_* hold.
//  - stop: no new req, fe_* and pc_r hold; responses still popped/enqueued/discarded (space reserved).
//  - Flush (exception|return, !stop): pc_r=EXC_PC or ret_pc next edge; queue cleared; fe_valid=0,
//    fe_inst=0, fe_pc=target; discard = inflight + addr_ok_fire - data_ok_fire (this cycle's data_ok
//    and any addr_ok accepted in flush cycle are discarded). inst_req=0 in flush cycle.
//  - exception and return together: EXC_PC used. Flush during discard>0: discard recomputed as above.
//  - Full: inflight+count==DEPTH -> inst_req=0 until a slot frees. Empty queue + stall: hold.
// STRUCTURE
//  - cpu_defs_pkg: RESET_PC, EXC_PC, NOP (32'h0), PC_INC (4), pc_t/inst_t typedefs.
//  - One sub-module: fetch_fifo (sync FIFO, WIDTH/DEPTH params, push/pop/clear, count, full/empty),
//    instanced twice: tag FIFO (32b) and instruction queue (64b {pc,inst}).
//  - Top: PC register, inflight/discard counters ($clog2(DEPTH+1) bits), output register.
// TESTING
//  1 Reset then addr_ok/data_ok every cycle, rdata=pc^1 -> fe_pc 0xbfc00000,..04,..08 consecutive,
//    fe_valid=1 from cycle 2 after first data_ok-cycle edge, inst_addr increments by 4.
//  2 addr_ok always, data_ok never -> exactly DEPTH(4) accepted, inst_req=0 afterwards, inflight=4.
//  3 stall 5 cycles with responses flowing -> fe_* hold, queue fills to 4, req drops; release ->
//    four queued pcs emitted in order, no loss or duplicate.
//  4 3 requests in flight, exception -> next inst_addr=0xbfc00380, 3 stale data_ok dropped,
//    first fe_valid=1 carries fe_pc=0xbfc00380; same with return, ret_pc=0x80001234.
//  5 exception+return same cycle -> target 0xbfc00380; stop+exception -> flush ignored, all hold.
//  6 pc_r=0xfffffffc, one fetch -> next inst_addr=0x00000000 (wrap).

Source files
------------

// File: rtl/fetch_queue_stage_pkg.sv
// Shared CPU front-end definitions: PC/instruction types, reset and exception vectors.
package fetch_queue_stage_pkg;

    typedef logic [31:0] pc_t;
    typedef logic [31:0] inst_t;

    typedef struct packed {
        pc_t   pc;
        inst_t inst;
    } fe_entry_t;

    localparam pc_t   RESET_PC_DEF = 32'hbfc00000;
    localparam pc_t   EXC_PC_DEF   = 32'hbfc00380;
    localparam inst_t NOP          = 32'h0;
    localparam pc_t   PC_INC       = 32'd4;

endpackage

// File: rtl/fetch_queue_stage_if.sv
// SRAM-like instruction bus: req/addr handshake, in-order data return.
interface fetch_queue_stage_if;
    import fetch_queue_stage_pkg::*;

    logic  inst_req;
    pc_t   inst_addr;
    logic  inst_addr_ok;
    logic  inst_data_ok;
    inst_t inst_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_addr_ok,
        input  inst_data_ok,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_addr_ok,
        output inst_data_ok,
        output inst_rdata
    );

endinterface

// File: rtl/fetch_queue_stage_fifo.sv
// Synchronous FIFO with clear; DEPTH must be a power of two.
module fetch_queue_stage_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q;

    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop)  rptr_q <= rptr_q + AW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem[wptr_q] <= wdata;
    end

    assign rdata = mem[rptr_q];
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    a_no_overflow:  assert property (@(posedge clk) disable iff (!resetn)
                                     !(push && full && !pop && !clear));
    a_no_underflow: assert property (@(posedge clk) disable iff (!resetn)
                                     !(pop && empty && !clear));

endmodule

// File: rtl/fetch_queue_stage.sv
// Pipelined IF stage: credit-limited fetch issue, response queue, flush with discard of
// in-flight responses, registered {pc,inst} output to decode.
module fetch_queue_stage
    import fetch_queue_stage_pkg::*;
#(
    parameter pc_t         RESET_PC = RESET_PC_DEF,
    parameter pc_t         EXC_PC   = EXC_PC_DEF,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       stall,
    input  logic                       stop,
    input  logic                       exception,
    input  logic                       eret,
    input  pc_t                        ret_pc,
    fetch_queue_stage_if.master        bus,
    output logic                       fe_valid,
    output pc_t                        fe_pc,
    output inst_t                      fe_inst
);

    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam logic [CW:0] SLOTS = (CW + 1)'(DEPTH);

    pc_t           pc_q, pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] discard_q, discard_d;
    logic          fe_valid_q, fe_valid_d;
    pc_t           fe_pc_q, fe_pc_d;
    inst_t         fe_inst_q, fe_inst_d;

    logic          flush, accept, addr_fire, data_fire, drop, word_valid, bypass;
    logic          q_push, q_pop, q_full, q_empty, tag_full, tag_empty;
    logic [CW-1:0] q_count, tag_count;
    logic [CW:0]   used_slots;
    pc_t           flush_pc, tag_pc;
    fe_entry_t     q_head;

    assign flush      = (exception | eret) & ~stop;
    assign flush_pc   = exception ? EXC_PC : ret_pc;
    assign accept     = ~stall & ~stop;
    // Queue slots are reserved at issue time so returning words always have room.
    assign used_slots = {1'b0, inflight_q} + {1'b0, q_count};

    assign bus.inst_req  = resetn & ~stop & ~flush & (used_slots < SLOTS);
    assign bus.inst_addr = pc_q;

    assign addr_fire  = bus.inst_req & bus.inst_addr_ok;
    assign data_fire  = bus.inst_data_ok;
    assign drop       = data_fire & (flush | (discard_q != '0));
    assign word_valid = data_fire & ~drop;
    assign q_pop      = accept & ~q_empty & ~flush;
    assign bypass     = accept & q_empty & word_valid;
    assign q_push     = word_valid & ~bypass;

    fetch_queue_stage_fifo #(
        .WIDTH ($bits(pc_t)),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk    (clk),
        .resetn (resetn),
        .clear  (1'b0),
        .push   (addr_fire),
        .wdata  (pc_q),
        .pop    (data_fire),
        .rdata  (tag_pc),
        .count  (tag_count),
        .full   (tag_full),
        .empty  (tag_empty)
    );

    fetch_queue_stage_fifo #(
        .WIDTH ($bits(fe_entry_t)),
        .DEPTH (DEPTH)
    ) u_inst_queue (
        .clk    (clk),
        .resetn (resetn),
        .clear  (flush),
        .push   (q_push),
        .wdata  ({tag_pc, bus.inst_rdata}),
        .pop    (q_pop),
        .rdata  (q_head),
        .count  (q_count),
        .full   (q_full),
        .empty  (q_empty)
    );

    always_comb begin
        pc_d       = pc_q;
        inflight_d = inflight_q + CW'(addr_fire) - CW'(data_fire);
        discard_d  = discard_q;
        fe_valid_d = fe_valid_q;
        fe_pc_d    = fe_pc_q;
        fe_inst_d  = fe_inst_q;

        if (flush) begin
            pc_d = flush_pc;
        end else if (addr_fire) begin
            pc_d = pc_q + PC_INC;
        end

        // Everything still outstanding after a flush cycle belongs to the old path.
        if (flush) begin
            discard_d = inflight_d;
        end else if (data_fire && (discard_q != '0)) begin
            discard_d = discard_q - CW'(1);
        end

        if (flush) begin
            fe_valid_d = 1'b0;
            fe_pc_d    = flush_pc;
            fe_inst_d  = NOP;
        end else if (accept) begin
            if (q_pop) begin
                fe_valid_d = 1'b1;
                fe_pc_d    = q_head.pc;
                fe_inst_d  = q_head.inst;
            end else if (bypass) begin
                fe_valid_d = 1'b1;
                fe_pc_d    = tag_pc;
                fe_inst_d  = bus.inst_rdata;
            end else begin
                fe_valid_d = 1'b0;
                fe_inst_d  = NOP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
            fe_valid_q <= 1'b0;
            fe_pc_q    <= RESET_PC;
            fe_inst_q  <= NOP;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            fe_valid_q <= fe_valid_d;
            fe_pc_q    <= fe_pc_d;
            fe_inst_q  <= fe_inst_d;
        end
    end

    assign fe_valid = fe_valid_q;
    assign fe_pc    = fe_pc_q;
    assign fe_inst  = fe_inst_q;

    a_tag_track: assert property (@(posedge clk) disable iff (!resetn)
                                  tag_count == inflight_q);
    a_data_ok:   assert property (@(posedge clk) disable iff (!resetn)
                                  !(data_fire && tag_empty));
    a_tag_room:  assert property (@(posedge clk) disable iff (!resetn)
                                  !(addr_fire && tag_full && !data_fire));
    a_q_room:    assert property (@(posedge clk) disable iff (!resetn)
                                  !(q_push && q_full && !q_pop));

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Scoreboard bench: accepted fetch addresses are expected, in order, on the decode side.
module tb_fetch_queue_stage;
    import fetch_queue_stage_pkg::*;

    localparam logic [31:0] RST = 32'hbfc00000;
    localparam logic [31:0] EXC = 32'hbfc00380;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        stall = 1'b0, stop = 1'b0, exception = 1'b0, eret = 1'b0;
    logic [31:0] ret_pc = 32'h0;
    logic        fe_valid;
    logic [31:0] fe_pc, fe_inst;

    fetch_queue_stage_if bus ();

    fetch_queue_stage #(
        .RESET_PC (RST),
        .EXC_PC   (EXC),
        .DEPTH    (4)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .stall     (stall),
        .stop      (stop),
        .exception (exception),
        .eret      (eret),
        .ret_pc    (ret_pc),
        .bus       (bus),
        .fe_valid  (fe_valid),
        .fe_pc     (fe_pc),
        .fe_inst   (fe_inst)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          fires = 0;
    logic [31:0] pend[$];
    logic [31:0] exp_q[$];
    logic [31:0] model_pc = RST;
    logic        addr_en = 1'b0, data_en = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
        end
    endtask

    // One bus cycle: drive responses, check outputs, advance the reference model.
    task automatic tick();
        logic        fire, flushing;
        logic [31:0] a, e;
        bus.inst_addr_ok = addr_en;
        bus.inst_data_ok = data_en && (pend.size() > 0);
        bus.inst_rdata   = (pend.size() > 0) ? (pend[0] ^ 32'h1) : 32'h0;
        #1;
        fire     = bus.inst_req && bus.inst_addr_ok;
        a        = bus.inst_addr;
        flushing = (exception || eret) && !stop;
        if (!resetn) begin
            check_eq("req_in_reset", 32'(bus.inst_req), 32'd0);
        end else begin
            if (bus.inst_req) check_eq("inst_addr", a, model_pc);
            if (flushing) check_eq("req_in_flush", 32'(bus.inst_req), 32'd0);
            if (stop) check_eq("req_in_stop", 32'(bus.inst_req), 32'd0);
            if (!fe_valid) check_eq("fe_inst_zero", fe_inst, 32'd0);
            if (fe_valid && !stall && !stop && !exception && !eret) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_out", 32'(fe_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("fe_pc", fe_pc, e);
                    check_eq("fe_inst", fe_inst, e ^ 32'h1);
                end
            end
        end
        @(posedge clk);
        if (!resetn) begin
            pend.delete();
            exp_q.delete();
            model_pc = RST;
        end else begin
            if (bus.inst_data_ok) e = pend.pop_front();
            if (fire) begin
                pend.push_back(a);
                exp_q.push_back(a);
                model_pc = a + 32'd4;
                fires++;
            end
            if (flushing) begin
                exp_q.delete();
                model_pc = exception ? EXC : ret_pc;
            end
        end
        @(negedge clk);
    endtask

    task automatic drain();
        stall = 1'b0; stop = 1'b0; exception = 1'b0; eret = 1'b0;
        addr_en = 1'b0; data_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0 && pend.size() == 0) break;
            tick();
        end
        check_eq("drain_left", 32'(exp_q.size() + pend.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held_pc, held_inst, held_addr;
        logic        held_valid;
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata   = 32'h0;
        @(negedge clk);
        repeat (2) tick();
        check_eq("rst_fe_valid", 32'(fe_valid), 32'd0);
        check_eq("rst_fe_pc", fe_pc, RST);
        check_eq("rst_fe_inst", fe_inst, 32'd0);
        resetn = 1'b1;
        #1;
        check_eq("rst_inst_addr", bus.inst_addr, RST);

        // Streaming: first word visible two cycles after the first request
        addr_en = 1'b1; data_en = 1'b1;
        check_eq("t1_c0_valid", 32'(fe_valid), 32'd0);
        tick();
        check_eq("t1_c1_valid", 32'(fe_valid), 32'd0);
        tick();
        check_eq("t1_c2_valid", 32'(fe_valid), 32'd1);
        check_eq("t1_c2_pc", fe_pc, RST);
        repeat (6) tick();
        drain();

        // Credit limit with no responses
        addr_en = 1'b1; data_en = 1'b0; fires = 0;
        repeat (8) tick();
        check_eq("t2_fires", 32'(fires), 32'd4);
        check_eq("t2_req_low", 32'(bus.inst_req), 32'd0);
        drain();

        // Stall with responses flowing
        addr_en = 1'b1; data_en = 1'b1;
        repeat (3) tick();
        held_pc = fe_pc; held_inst = fe_inst;
        stall = 1'b1;
        repeat (5) begin
            tick();
            check_eq("t3_hold_pc", fe_pc, held_pc);
            check_eq("t3_hold_inst", fe_inst, held_inst);
        end
        check_eq("t3_req_full", 32'(bus.inst_req), 32'd0);
        stall = 1'b0;
        repeat (10) tick();
        drain();

        // Exception with three requests in flight
        addr_en = 1'b1; data_en = 1'b0;
        repeat (3) tick();
        addr_en = 1'b0; exception = 1'b1;
        tick();
        exception = 1'b0;
        check_eq("t4_exc_valid", 32'(fe_valid), 32'd0);
        check_eq("t4_exc_fe_pc", fe_pc, EXC);
        check_eq("t4_exc_addr", bus.inst_addr, EXC);
        addr_en = 1'b1; data_en = 1'b1;
        repeat (8) tick();
        drain();

        // Eret with a stale response returning in the flush cycle
        addr_en = 1'b1; data_en = 1'b0; ret_pc = 32'h80001234;
        repeat (3) tick();
        addr_en = 1'b0; data_en = 1'b1; eret = 1'b1;
        tick();
        eret = 1'b0;
        check_eq("t4_ret_fe_pc", fe_pc, 32'h80001234);
        check_eq("t4_ret_addr", bus.inst_addr, 32'h80001234);
        addr_en = 1'b1;
        repeat (8) tick();
        drain();

        // Exception and eret together
        addr_en = 1'b1; ret_pc = 32'h80005678;
        repeat (2) tick();
        exception = 1'b1; eret = 1'b1;
        tick();
        exception = 1'b0; eret = 1'b0;
        check_eq("t5_both_addr", bus.inst_addr, EXC);
        check_eq("t5_both_fe_pc", fe_pc, EXC);
        repeat (4) tick();

        // Stop masks an exception
        held_pc = fe_pc; held_inst = fe_inst; held_valid = fe_valid;
        held_addr = bus.inst_addr;
        stop = 1'b1; exception = 1'b1;
        tick();
        check_eq("t5_stop_pc", fe_pc, held_pc);
        check_eq("t5_stop_inst", fe_inst, held_inst);
        check_eq("t5_stop_valid", 32'(fe_valid), 32'(held_valid));
        check_eq("t5_stop_addr", bus.inst_addr, held_addr);
        stop = 1'b0; exception = 1'b0;
        repeat (6) tick();
        drain();

        // PC wrap
        ret_pc = 32'hfffffffc; eret = 1'b1;
        tick();
        eret = 1'b0; addr_en = 1'b1; data_en = 1'b0;
        tick();
        addr_en = 1'b0;
        check_eq("t6_wrap", bus.inst_addr, 32'h0);
        drain();

        // Random mix
        for (int i = 0; i < 300; i++) begin
            addr_en   = ($urandom_range(0, 3) != 0);
            data_en   = ($urandom_range(0, 1) != 0);
            stall     = ($urandom_range(0, 3) == 0);
            stop      = ($urandom_range(0, 9) == 0);
            exception = ($urandom_range(0, 49) == 0);
            eret      = ($urandom_range(0, 59) == 0);
            ret_pc    = {$urandom_range(0, 65535), 14'h0, 2'b00};
            tick();
        end
        drain();

        // Reset in the middle of traffic
        addr_en = 1'b1; data_en = 1'b1;
        repeat (3) tick();
        resetn = 1'b0;
        tick();
        check_eq("mid_rst_valid", 32'(fe_valid), 32'd0);
        check_eq("mid_rst_pc", fe_pc, RST);
        resetn = 1'b1;
        repeat (6) tick();
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
